// File: rtl/timekeeper.sv
// -----------------------------------------------------------------------------
// timekeeper
//
// Time-of-day counter (HH:MM:SS, 24-hour) held directly in BCD. A slow tick
// from an external divider is prescaled to seconds; two push buttons let the
// user set minutes and hours. All three inputs are asynchronous to the clock
// and are synchronized and edge-detected before use.
//
// Parameters
//   TICKS_PER_SEC  tick_in rising edges per second (1..255)
//
// Ports
//   clock      in   system clock, all state changes on its rising edge
//   reset_n    in   asynchronous active-low reset
//   tick_in    in   slow square wave, one tick per rising edge (async)
//   inc_min    in   minute-set button, one increment per 0->1 (async)
//   inc_hour   in   hour-set button, one increment per 0->1 (async)
//   sec_bcd    out  seconds, two BCD digits 00..59
//   min_bcd    out  minutes, two BCD digits 00..59
//   hour_bcd   out  hours, two BCD digits 00..23
//   sec_pulse  out  one-cycle strobe after seconds advance from a tick carry
//
// There is no handshake on this block: inputs are level signals sampled every
// clock, outputs are plain registers that are always valid.
// -----------------------------------------------------------------------------
module timekeeper #(
   parameter int unsigned TICKS_PER_SEC = 100
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       tick_in,
   input  logic       inc_min,
   input  logic       inc_hour,
   output logic [7:0] sec_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] hour_bcd,
   output logic       sec_pulse
);

   localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_SEC - 1);

   // [0] and [1] form the two-flop synchronizer, [2] is the edge-detect flop.
   logic [2:0] tick_sync;
   logic [2:0] min_sync;
   logic [2:0] hour_sync;

   logic [7:0] prescaler;

   logic tick_rise;
   logic min_rise;
   logic hour_rise;
   logic sec_carry;
   logic min_carry;
   logic hour_carry;

   // Advance a two-digit BCD value by one, wrapping from 'last' to 00.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                          input logic [7:0] last);
      logic [7:0] r;
      if (v == last)
         r = 8'h00;
      else if (v[3:0] == 4'h9)
         r = {v[7:4] + 4'h1, 4'h0};
      else
         r = {v[7:4], v[3:0] + 4'h1};
      return r;
   endfunction

   assign tick_rise = tick_sync[1] & ~tick_sync[2];
   assign min_rise  = min_sync[1]  & ~min_sync[2];
   assign hour_rise = hour_sync[1] & ~hour_sync[2];

   assign sec_carry  = tick_rise & (prescaler == PRESC_LAST);
   // A minute-set press clears the seconds, so it swallows any carry
   // that arrives in the same cycle; minutes then advance only once.
   assign min_carry  = sec_carry & (sec_bcd == 8'h59) & ~min_rise;
   assign hour_carry = min_carry & (min_bcd == 8'h59);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         // Synchronizers preset high: an input already high at release
         // must not look like a fresh rising edge.
         tick_sync <= 3'b111;
         min_sync  <= 3'b111;
         hour_sync <= 3'b111;
         prescaler <= 8'h00;
         sec_bcd   <= 8'h00;
         min_bcd   <= 8'h00;
         hour_bcd  <= 8'h00;
         sec_pulse <= 1'b0;
      end else begin
         tick_sync <= {tick_sync[1:0], tick_in};
         min_sync  <= {min_sync[1:0],  inc_min};
         hour_sync <= {hour_sync[1:0], inc_hour};

         sec_pulse <= sec_carry & ~min_rise;

         if (min_rise) begin
            prescaler <= 8'h00;
            sec_bcd   <= 8'h00;
            min_bcd   <= bcd_inc(min_bcd, 8'h59);
         end else if (tick_rise) begin
            if (sec_carry) begin
               prescaler <= 8'h00;
               sec_bcd   <= bcd_inc(sec_bcd, 8'h59);
               if (min_carry)
                  min_bcd <= bcd_inc(min_bcd, 8'h59);
            end else begin
               prescaler <= prescaler + 8'h01;
            end
         end

         // A button press and a carry in the same cycle still count once.
         if (hour_rise | hour_carry)
            hour_bcd <= bcd_inc(hour_bcd, 8'h23);
      end
   end

endmodule

// File: tb/tb_timekeeper.sv
module tb_timekeeper;

   localparam int TPS = 100;

   logic       clock    = 1'b0;
   logic       reset_n  = 1'b0;
   logic       tick_in  = 1'b0;
   logic       inc_min  = 1'b0;
   logic       inc_hour = 1'b0;
   logic [7:0] sec_bcd;
   logic [7:0] min_bcd;
   logic [7:0] hour_bcd;
   logic       sec_pulse;

   int total = 0;
   int bad   = 0;

   // Reference time kept as plain integers.
   int mh, mm, ms, mp;
   // Expected seconds value seen with each sec_pulse.
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;

   timekeeper #(.TICKS_PER_SEC(TPS)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .tick_in   (tick_in),
      .inc_min   (inc_min),
      .inc_hour  (inc_hour),
      .sec_bcd   (sec_bcd),
      .min_bcd   (min_bcd),
      .hour_bcd  (hour_bcd),
      .sec_pulse (sec_pulse)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clock = ~clock;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] t;
      logic [3:0] u;
      t = 4'(v / 10);
      u = 4'(v % 10);
      return {t, u};
   endfunction

   function automatic logic [23:0] model_time();
      return {to_bcd(mh), to_bcd(mm), to_bcd(ms)};
   endfunction

   task automatic model_reset();
      mh = 0; mm = 0; ms = 0; mp = 0;
      exp_q.delete();
   endtask

   task automatic model_event(input bit t, input bit mi, input bit hi);
      bit hc;
      hc = 1'b0;
      if (mi) begin
         mm = (mm + 1) % 60;
         ms = 0;
         mp = 0;
      end else if (t) begin
         if (mp == TPS - 1) begin
            mp = 0;
            ms = ms + 1;
            if (ms == 60) begin
               ms = 0;
               mm = mm + 1;
               if (mm == 60) begin
                  mm = 0;
                  hc = 1'b1;
               end
            end
            exp_q.push_back(to_bcd(ms));
         end else begin
            mp = mp + 1;
         end
      end
      if (hi || hc)
         mh = (mh + 1) % 24;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_event(input bit t, input bit mi, input bit hi,
                              input int low_cycles);
      @(negedge clock);
      tick_in  = t;
      inc_min  = mi;
      inc_hour = hi;
      model_event(t, mi, hi);
      @(negedge clock);
      tick_in  = 1'b0;
      inc_min  = 1'b0;
      inc_hour = 1'b0;
      repeat (low_cycles - 1) @(negedge clock);
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) drive_event(1'b1, 1'b0, 1'b0, 1);
   endtask

   task automatic press_min(input int n);
      for (int i = 0; i < n; i++) drive_event(1'b0, 1'b1, 1'b0, 1);
   endtask

   task automatic press_hour(input int n);
      for (int i = 0; i < n; i++) drive_event(1'b0, 1'b0, 1'b1, 1);
   endtask

   task automatic settle();
      repeat (4) @(negedge clock);
   endtask

   // ---------------- scoreboard: sec_pulse monitor ----------------
   always @(negedge clock) begin
      if (reset_n && sec_pulse) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sec_pulse_unexpected: pulse seen with sec_bcd=%h, required no pulse", sec_bcd);
         end else begin
            mon_exp = exp_q.pop_front();
            if (sec_bcd !== mon_exp) begin
               bad++;
               $display("FAIL sec_pulse_value: sec_bcd=%h at pulse, required %h", sec_bcd, mon_exp);
            end
         end
      end
   end

   // ---------------- tests ----------------
   task automatic test_reset();
      model_reset();
      repeat (2) @(negedge clock);
      total++;
      if ({hour_bcd, min_bcd, sec_bcd, sec_pulse} !== 25'h0) begin
         bad++;
         $display("FAIL reset_hold: got %h:%h:%h pulse=%b, required 00:00:00 pulse=0",
                  hour_bcd, min_bcd, sec_bcd, sec_pulse);
      end
      reset_n = 1'b1;
      settle();
      total++;
      if ({hour_bcd, min_bcd, sec_bcd} !== model_time()) begin
         bad++;
         $display("FAIL reset_release: got %h%h%h, required %h", hour_bcd, min_bcd, sec_bcd, model_time());
      end
   endtask

   task automatic test_one_second();
      run_ticks(TPS - 1);
      settle();
      total++;
      if ({hour_bcd, min_bcd, sec_bcd, sec_pulse} !== 25'h0) begin
         bad++;
         $display("FAIL pre_second: got %h%h%h pulse=%b, required 000000 pulse=0",
                  hour_bcd, min_bcd, sec_bcd, sec_pulse);
      end
      // 100th rise driven here; update is due two edges after it is sampled.
      @(negedge clock);
      tick_in = 1'b1;
      model_event(1'b1, 1'b0, 1'b0);
      for (int n = 1; n <= 2; n++) begin
         @(negedge clock);
         tick_in = 1'b0;
         total++;
         if (sec_bcd !== 8'h00 || sec_pulse !== 1'b0) begin
            bad++;
            $display("FAIL second_early: cycle %0d sec=%h pulse=%b, required sec=00 pulse=0", n, sec_bcd, sec_pulse);
         end
      end
      @(negedge clock);
      total++;
      if (sec_bcd !== 8'h01 || sec_pulse !== 1'b1) begin
         bad++;
         $display("FAIL second_latency: sec=%h pulse=%b, required sec=01 pulse=1", sec_bcd, sec_pulse);
      end
      @(negedge clock);
      total++;
      if (sec_pulse !== 1'b0) begin
         bad++;
         $display("FAIL second_pulse_width: pulse=%b, required 0", sec_pulse);
      end
   endtask

   task automatic test_inc_min_hold();
      run_ticks(36 * TPS);
      settle();
      total++;
      if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000037) begin
         bad++;
         $display("FAIL preload_37: got %h%h%h, required 000037", hour_bcd, min_bcd, sec_bcd);
      end
      @(negedge clock);
      inc_min = 1'b1;
      model_event(1'b0, 1'b1, 1'b0);
      repeat (1000) @(negedge clock);
      inc_min = 1'b0;
      settle();
      total++;
      if ({hour_bcd, min_bcd, sec_bcd} !== model_time() || min_bcd !== 8'h01 || sec_bcd !== 8'h00) begin
         bad++;
         $display("FAIL inc_min_hold: got %h%h%h, required %h", hour_bcd, min_bcd, sec_bcd, model_time());
      end
   endtask

   task automatic test_reset_mid();
      press_hour(5);
      press_min(16);
      run_ticks(42 * TPS + 50);
      settle();
      total++;
      if ({hour_bcd, min_bcd, sec_bcd} !== 24'h051742) begin
         bad++;
         $display("FAIL preload_051742: got %h%h%h, required 051742", hour_bcd, min_bcd, sec_bcd);
      end
      @(negedge clock);
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      total++;
      if ({hour_bcd, min_bcd, sec_bcd, sec_pulse} !== 25'h0) begin
         bad++;
         $display("FAIL async_reset: got %h%h%h pulse=%b before clock edge, required 000000 pulse=0",
                  hour_bcd, min_bcd, sec_bcd, sec_pulse);
      end
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      run_ticks(TPS);
      settle();
      total++;
      if ({hour_bcd, min_bcd, sec_bcd} !== model_time() || sec_bcd !== 8'h01) begin
         bad++;
         $display("FAIL restart_count: got %h%h%h, required %h", hour_bcd, min_bcd, sec_bcd, model_time());
      end
   endtask

   task automatic test_tick_high_reset();
      @(negedge clock);
      tick_in = 1'b1;
      repeat (2) @(negedge clock);
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (5) @(negedge clock);
      tick_in = 1'b0;
      // First real rise sets the prescaler to 1; 98 more leave it at 99.
      run_ticks(TPS - 1);
      settle();
      total++;
      if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000) begin
         bad++;
         $display("FAIL no_spurious_tick: got %h%h%h, required 000000", hour_bcd, min_bcd, sec_bcd);
      end
      run_ticks(1);
      settle();
      total++;
      if ({hour_bcd, min_bcd, sec_bcd} !== model_time() || sec_bcd !== 8'h01) begin
         bad++;
         $display("FAIL first_tick_counted: got %h%h%h, required %h", hour_bcd, min_bcd, sec_bcd, model_time());
      end
   endtask

   task automatic test_min_collision();
      press_hour(12);
      press_min(59);
      run_ticks(60 * TPS - 1);
      settle();
      total++;
      if ({hour_bcd, min_bcd, sec_bcd} !== 24'h125959) begin
         bad++;
         $display("FAIL preload_125959: got %h%h%h, required 125959", hour_bcd, min_bcd, sec_bcd);
      end
      drive_event(1'b1, 1'b1, 1'b0, 1);
      settle();
      total++;
      if ({hour_bcd, min_bcd, sec_bcd} !== model_time() || model_time() !== 24'h120000) begin
         bad++;
         $display("FAIL min_collision: got %h%h%h, required 120000", hour_bcd, min_bcd, sec_bcd);
      end
   endtask

   task automatic test_hour_collision();
      press_hour(10);
      press_min(59);
      run_ticks(60 * TPS - 1);
      drive_event(1'b1, 1'b0, 1'b1, 1);
      settle();
      total++;
      if ({hour_bcd, min_bcd, sec_bcd} !== model_time() || hour_bcd !== 8'h23) begin
         bad++;
         $display("FAIL hour_collision: got %h%h%h, required %h", hour_bcd, min_bcd, sec_bcd, model_time());
      end
   endtask

   task automatic test_midnight();
      press_min(59);
      run_ticks(59 * TPS);
      settle();
      total++;
      if ({hour_bcd, min_bcd, sec_bcd} !== 24'h235959) begin
         bad++;
         $display("FAIL preload_235959: got %h%h%h, required 235959", hour_bcd, min_bcd, sec_bcd);
      end
      run_ticks(TPS);
      settle();
      total++;
      if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL midnight_wrap: got %h%h%h pending_pulses=%0d, required 000000 and 0",
                  hour_bcd, min_bcd, sec_bcd, exp_q.size());
      end
   endtask

   task automatic test_both_buttons();
      run_ticks(2 * TPS + 50);
      drive_event(1'b0, 1'b1, 1'b1, 1);
      settle();
      total++;
      if ({hour_bcd, min_bcd, sec_bcd} !== model_time() || model_time() !== 24'h010100) begin
         bad++;
         $display("FAIL both_buttons: got %h%h%h, required 010100", hour_bcd, min_bcd, sec_bcd);
      end
      // Prescaler must have cleared: one second needs a full TPS ticks again.
      run_ticks(TPS - 1);
      settle();
      total++;
      if (sec_bcd !== 8'h00) begin
         bad++;
         $display("FAIL both_buttons_presc: sec=%h, required 00", sec_bcd);
      end
   endtask

   task automatic test_random();
      int r;
      bit t, mi, hi;
      for (int i = 1; i <= 600; i++) begin
         r  = $urandom_range(0, 19);
         t  = (r < 16);
         mi = (r == 16) || (r == 19 && $urandom_range(0, 1) == 1);
         hi = (r == 17) || (r == 19 && $urandom_range(0, 1) == 1);
         if (r == 18) begin
            t  = 1'b1;
            mi = ($urandom_range(0, 1) == 1);
            hi = ($urandom_range(0, 1) == 1);
         end
         drive_event(t, mi, hi, $urandom_range(1, 3));
         if (i % 100 == 0) begin
            settle();
            total++;
            if ({hour_bcd, min_bcd, sec_bcd} !== model_time()) begin
               bad++;
               $display("FAIL random_%0d: got %h%h%h, required %h", i, hour_bcd, min_bcd, sec_bcd, model_time());
            end
         end
      end
   endtask

   task automatic test_pulses_drained();
      settle();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL pulses_missing: %0d expected pulses never seen, required 0", exp_q.size());
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_one_second();
      test_inc_min_hold();
      test_reset_mid();
      test_tick_high_reset();
      test_min_collision();
      test_hour_collision();
      test_midnight();
      test_both_buttons();
      test_random();
      test_pulses_drained();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/timekeeper.md
TIMEKEEPER -- requirements
Module: timekeeper

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100: number of tick_in rising edges per elapsed second; legal range 1..255.
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset; assertion acts immediately, release is taken on a clock edge.
REQ-004 tick_in  input  1  slow square wave from the frequency divider, asynchronous to clock; each rising edge is one tick.
REQ-005 inc_min  input  1  minute-set button, asynchronous level; one increment per 0->1 transition.
REQ-006 inc_hour  input  1  hour-set button, asynchronous level; one increment per 0->1 transition.
REQ-007 sec_bcd  output  8  seconds as two BCD digits: [7:4] tens 0..5, [3:0] units 0..9.
REQ-008 min_bcd  output  8  minutes as two BCD digits: [7:4] tens 0..5, [3:0] units 0..9.
REQ-009 hour_bcd  output  8  hours as two BCD digits 00..23: [7:4] tens 0..2, [3:0] units 0..9.
REQ-010 sec_pulse  output  1  one-clock-cycle strobe issued each time seconds advance from a tick carry.

Function
REQ-011 tick_in, inc_min and inc_hour SHALL each pass through a two-flop synchronizer, followed by a third flop used for rising-edge detection (rise = stage2 & ~stage3).
REQ-012 Input latency: a 0->1 transition sampled at clock edge k SHALL update the counters at edge k+2; pulses shorter than one clock period are not guaranteed to be seen.
REQ-013 Prescaler, 8-bit: on each tick rise it SHALL increment; when it reaches TICKS_PER_SEC-1 it SHALL instead wrap to 0 and generate a second carry.
REQ-014 Time counters SHALL be held directly as BCD digits; non-BCD digit values are never produced.
REQ-015 Second carry: the seconds SHALL advance by one, 59 wraps to 00 and carries into the minutes.
REQ-016 Minute carry: the minutes SHALL advance by one, 59 wraps to 00 and carries into the hours.
REQ-017 Hours: 23 SHALL wrap to 00; there is no carry out and no date.
REQ-018 inc_min rise: the minutes SHALL advance by one (59 wraps to 00 with no hour carry); seconds and prescaler SHALL clear to 0.
REQ-019 inc_hour rise: the hours SHALL advance by one (23 wraps to 00); minutes, seconds and prescaler are unaffected.
REQ-020 Simultaneous inc_min rise and second carry in one cycle: the minutes SHALL advance by exactly one, the seconds become 00, and sec_pulse is not asserted.
REQ-021 Simultaneous inc_hour rise and minute carry in one cycle: the hours SHALL advance by exactly one.
REQ-022 Simultaneous inc_min and inc_hour rises: both SHALL apply (minutes +1 without carry, hours +1, seconds and prescaler cleared).
REQ-023 sec_pulse SHALL be registered and high for exactly the one cycle following an edge on which the seconds advanced from a carry.
REQ-024 Outputs SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-025 reset_n low SHALL force sec_bcd, min_bcd and hour_bcd to 8'h00, sec_pulse to 0 and the prescaler to 0.
REQ-026 During reset, all synchronizer and edge-detect flops SHALL be set to 1, so an input already high at reset release produces no spurious rise.
REQ-027 Reset asserted mid-count SHALL abort the operation immediately, with no partial update visible after release.
REQ-028 The first tick counted after reset release SHALL be the first 0->1 transition of tick_in.

Verification
REQ-029 Reset, then 100 tick_in rises (TICKS_PER_SEC=100) -> sec_bcd=8'h01, a single sec_pulse, 2 cycles after the 100th rise is sampled.
REQ-030 Preload 23:59:59 via buttons and ticks, then 100 tick rises -> hour_bcd/min_bcd/sec_bcd = 00/00/00, one sec_pulse.
REQ-031 At 00:00:37, press inc_min and hold it for 1000 cycles -> min_bcd=8'h01, sec_bcd=8'h00, exactly one increment.
REQ-032 At 12:59:59 with prescaler=99, inc_min rise and tick rise in the same cycle -> 12:00:00 (minutes wrap), sec_pulse stays low.
REQ-033 Hold tick_in high through reset release -> no count until tick_in goes 0 then 1; prescaler reads 1 after that rise.
REQ-034 Assert reset_n low asynchronously mid-second at 05:17:42 -> all outputs 0 before the next clock edge; counting restarts from 00:00:00.
